// File: rtl/perceptron_trainer_n.sv
// perceptron_trainer_n: N-input perceptron trainer, serial MAC, saturating update.
// Optional dead-zone decision: define PERCEPTRON_THETA_EN to add the theta input.
module perceptron_trainer_n #(
   parameter int N_IN   = 2,
   parameter int XW     = 7,
   parameter int WW     = 14,
   parameter int N_SMP  = 4,
   parameter int MAX_EP = 64,
   parameter int ALW    = 4,
   localparam int AW    = (N_SMP > 1) ? $clog2(N_SMP) : 1,
   localparam int YW    = WW + XW + $clog2(N_IN + 1),
   localparam int DW    = N_IN * XW + 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ALW-1:0]     alpha,
`ifdef PERCEPTRON_THETA_EN
   input  logic [WW-1:0]      theta,
`endif
   output logic               smp_rd,
   output logic [AW-1:0]      smp_addr,
   input  logic [DW-1:0]      smp_data,
   output logic               ready,
   output logic               done,
   output logic               converged,
   output logic [7:0]         epoch_cnt,
   output logic [N_IN*WW-1:0] w_flat,
   output logic [WW-1:0]      bias,
   output logic [YW-1:0]      y_out
);

   localparam int CW = $clog2(N_IN + 1);
   localparam int PW = WW + XW;
   localparam int MW = XW + ALW + 1;
   localparam int UW = WW + XW + ALW + 2;
   localparam logic [CW-1:0] K_LAST  = CW'(N_IN);
   localparam logic [AW-1:0] I_LAST  = AW'(N_SMP - 1);
   localparam logic [7:0]    EP_LAST = 8'(MAX_EP);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      ACC,
      DECIDE,
      UPDATE,
      EPEND,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0]             idx_q, idx_d;
   logic [CW-1:0]             k_q, k_d;
   logic [N_IN-1:0][XW-1:0]   x_q, x_d;
   logic                      tneg_q, tneg_d;
   logic [N_IN-1:0][WW-1:0]   w_q, w_d;
   logic [WW-1:0]             b_q, b_d;
   logic signed [YW-1:0]      acc_q, acc_d;
   logic [YW-1:0]             y_q, y_d;
   logic [7:0]                ep_q, ep_d;
   logic                      conv_q, conv_d;
   logic                      upd_q, upd_d;
   logic [ALW-1:0]            alpha_q, alpha_d;
   logic                      done_q, done_d;

   logic                      last_k;
   logic                      last_i;
   logic                      ep_lim;
   logic                      mis;
   logic [AW-1:0]             idx_nx;

   logic signed [WW-1:0]      w_sel;
   logic signed [XW-1:0]      x_sel;
   logic signed [PW-1:0]      w_ext, xw_ext, prod;
   logic signed [YW-1:0]      prod_ext;
   logic signed [MW-1:0]      a_ext, xa_ext, mag, delta;
   logic signed [UW-1:0]      sum;
   logic                      ovf;
   logic [WW-1:0]             newv;

   assign last_k = (k_q == K_LAST);
   assign last_i = (idx_q == I_LAST);
   assign ep_lim = ((ep_q + 8'd1) == EP_LAST);
   assign idx_nx = last_i ? '0 : idx_q + AW'(1);

   // Step 0 selects bias with unit input, so bias and weights share one path.
   always_comb begin
      w_sel = b_q;
      x_sel = XW'(1);
      for (int i = 0; i < N_IN; i++) begin
         if (k_q == CW'(i + 1)) begin
            w_sel = w_q[i];
            x_sel = x_q[i];
         end
      end
   end

   always_comb begin
      w_ext    = {{XW{w_sel[WW-1]}}, w_sel};
      xw_ext   = {{WW{x_sel[XW-1]}}, x_sel};
      prod     = w_ext * xw_ext;
      prod_ext = {{(YW-PW){prod[PW-1]}}, prod};
   end

   always_comb begin
      a_ext  = {{(XW+1){1'b0}}, alpha_q};
      xa_ext = {{(ALW+1){x_sel[XW-1]}}, x_sel};
      mag    = a_ext * xa_ext;
      delta  = tneg_q ? -mag : mag;
      sum    = {{(UW-WW){w_sel[WW-1]}}, w_sel}
             + {{(UW-MW){delta[MW-1]}}, delta};
      ovf    = (sum[UW-1:WW-1] != {(UW-WW+1){sum[UW-1]}});
      if (ovf) begin
         newv = sum[UW-1] ? {1'b1, {(WW-1){1'b0}}}
                          : {1'b0, {(WW-1){1'b1}}};
      end else begin
         newv = sum[WW-1:0];
      end
   end

`ifdef PERCEPTRON_THETA_EN
   logic signed [YW-1:0] thx, nthx;
   logic                 above, below;

   // A zero decision inside the dead zone never matches a bipolar target.
   always_comb begin
      thx   = {{(YW-WW){1'b0}}, theta};
      nthx  = -thx;
      above = (acc_q > thx);
      below = (acc_q < nthx);
      mis   = !((above && !tneg_q) || (below && tneg_q));
   end
`else
   always_comb begin
      mis = (acc_q[YW-1] != tneg_q);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = FETCH;
         FETCH:      state_d = LATCH;
         LATCH:      state_d = ACC;
         ACC:        if (last_k) state_d = DECIDE;
         DECIDE: begin
            if (mis)         state_d = UPDATE;
            else if (last_i) state_d = EPEND;
            else             state_d = FETCH;
         end
         UPDATE: begin
            if (last_k) state_d = last_i ? EPEND : FETCH;
         end
         EPEND: begin
            if (!upd_q || ep_lim) state_d = DONE;
            else                  state_d = FETCH;
         end
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      smp_rd = 1'b0;
      ready  = 1'b0;
      unique case (1'b1)
         (state_q == FETCH):                     smp_rd = 1'b1;
         (state_q == IDLE) || (state_q == DONE): ready  = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      idx_d   = idx_q;
      k_d     = k_q;
      x_d     = x_q;
      tneg_d  = tneg_q;
      w_d     = w_q;
      b_d     = b_q;
      acc_d   = acc_q;
      y_d     = y_q;
      ep_d    = ep_q;
      conv_d  = conv_q;
      upd_d   = upd_q;
      alpha_d = alpha_q;
      done_d  = (state_d == DONE) && (state_q != DONE);
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               alpha_d = alpha;
               w_d     = '0;
               b_d     = '0;
               ep_d    = '0;
               conv_d  = 1'b0;
               upd_d   = 1'b0;
               idx_d   = '0;
            end
         end
         LATCH: begin
            x_d    = smp_data[N_IN*XW-1:0];
            tneg_d = smp_data[DW-1] & smp_data[DW-2];
            acc_d  = '0;
            k_d    = '0;
         end
         ACC: begin
            acc_d = acc_q + prod_ext;
            k_d   = last_k ? '0 : k_q + CW'(1);
         end
         DECIDE: begin
            y_d = acc_q;
            if (mis) upd_d = 1'b1;
            else     idx_d = idx_nx;
         end
         UPDATE: begin
            if (k_q == '0) b_d = newv;
            for (int i = 0; i < N_IN; i++) begin
               if (k_q == CW'(i + 1)) w_d[i] = newv;
            end
            k_d = last_k ? '0 : k_q + CW'(1);
            if (last_k) idx_d = idx_nx;
         end
         EPEND: begin
            ep_d = ep_q + 8'd1;
            if (!upd_q)      conv_d = 1'b1;
            else if (ep_lim) conv_d = 1'b0;
            else             upd_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         k_q     <= '0;
         x_q     <= '0;
         tneg_q  <= 1'b0;
         w_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         ep_q    <= '0;
         conv_q  <= 1'b0;
         upd_q   <= 1'b0;
         alpha_q <= '0;
         done_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         k_q     <= k_d;
         x_q     <= x_d;
         tneg_q  <= tneg_d;
         w_q     <= w_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         ep_q    <= ep_d;
         conv_q  <= conv_d;
         upd_q   <= upd_d;
         alpha_q <= alpha_d;
         done_q  <= done_d;
      end
   end

   assign smp_addr  = idx_q;
   assign done      = done_q;
   assign converged = conv_q;
   assign epoch_cnt = ep_q;
   assign w_flat    = w_q;
   assign bias      = b_q;
   assign y_out     = y_q;

endmodule

// File: tb/tb_perceptron_trainer_n.sv
// Bench for perceptron_trainer_n: three configurations against an epoch-level model.
`timescale 1ns/1ps
module tb_perceptron_trainer_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start;
   logic [3:0] alpha;
   int         sel;
   logic       sa, sb, sc;
   assign sa = start && (sel == 0);
   assign sb = start && (sel == 1);
   assign sc = start && (sel == 2);

   logic rd_a, rdy_a, dn_a, cv_a;
   logic [1:0] ad_a; logic [15:0] d_a; logic [7:0] ep_a;
   logic [27:0] w_a; logic [13:0] b_a; logic [22:0] y_a;

   logic rd_b, rdy_b, dn_b, cv_b;
   logic [0:0] ad_b; logic [8:0] d_b; logic [7:0] ep_b;
   logic [7:0] w_b; logic [7:0] b_b; logic [15:0] y_b;

   logic rd_c, rdy_c, dn_c, cv_c;
   logic [0:0] ad_c; logic [15:0] d_c; logic [7:0] ep_c;
   logic [27:0] w_c; logic [13:0] b_c; logic [22:0] y_c;

   perceptron_trainer_n #(.N_IN(2), .XW(7), .WW(14), .N_SMP(4), .MAX_EP(5), .ALW(4)) u_a (
      .clk(clk), .rst(rst), .start(sa), .alpha(alpha),
      .smp_rd(rd_a), .smp_addr(ad_a), .smp_data(d_a),
      .ready(rdy_a), .done(dn_a), .converged(cv_a), .epoch_cnt(ep_a),
      .w_flat(w_a), .bias(b_a), .y_out(y_a));

   perceptron_trainer_n #(.N_IN(1), .XW(7), .WW(8), .N_SMP(1), .MAX_EP(64), .ALW(4)) u_b (
      .clk(clk), .rst(rst), .start(sb), .alpha(alpha),
      .smp_rd(rd_b), .smp_addr(ad_b), .smp_data(d_b),
      .ready(rdy_b), .done(dn_b), .converged(cv_b), .epoch_cnt(ep_b),
      .w_flat(w_b), .bias(b_b), .y_out(y_b));

   perceptron_trainer_n #(.N_IN(2), .XW(7), .WW(14), .N_SMP(1), .MAX_EP(64), .ALW(4)) u_c (
      .clk(clk), .rst(rst), .start(sc), .alpha(alpha),
      .smp_rd(rd_c), .smp_addr(ad_c), .smp_data(d_c),
      .ready(rdy_c), .done(dn_c), .converged(cv_c), .epoch_cnt(ep_c),
      .w_flat(w_c), .bias(b_c), .y_out(y_c));

   int mx [4][2];
   int mt [4];

   function automatic logic [1:0] tenc(input int t);
      return (t < 0) ? 2'b11 : 2'b01;
   endfunction

   always @(posedge clk) begin
      if (rd_a) d_a <= {tenc(mt[ad_a]), 7'(mx[ad_a][1]), 7'(mx[ad_a][0])};
      if (rd_b) d_b <= {tenc(mt[0]), 7'(mx[0][0])};
      if (rd_c) d_c <= {tenc(mt[0]), 7'(mx[0][1]), 7'(mx[0][0])};
   end

   logic rd_s, rdy_s, dn_s, cv_s;
   logic [7:0] ep_s;
   longint w0_s, w1_s, b_s, y_s;
   always_comb begin
      rd_s = rd_a; rdy_s = rdy_a; dn_s = dn_a; cv_s = cv_a; ep_s = ep_a;
      w0_s = longint'($signed(w_a[13:0]));
      w1_s = longint'($signed(w_a[27:14]));
      b_s  = longint'($signed(b_a));
      y_s  = longint'($signed(y_a));
      if (sel == 1) begin
         rd_s = rd_b; rdy_s = rdy_b; dn_s = dn_b; cv_s = cv_b; ep_s = ep_b;
         w0_s = longint'($signed(w_b));
         w1_s = 0;
         b_s  = longint'($signed(b_b));
         y_s  = longint'($signed(y_b));
      end else if (sel == 2) begin
         rd_s = rd_c; rdy_s = rdy_c; dn_s = dn_c; cv_s = cv_c; ep_s = ep_c;
         w0_s = longint'($signed(w_c[13:0]));
         w1_s = longint'($signed(w_c[27:14]));
         b_s  = longint'($signed(b_c));
         y_s  = longint'($signed(y_c));
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input longint obs, input longint want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // Configuration of the selected instance: inputs, samples, weight width, epoch limit.
   int cfg_n, cfg_s, cfg_w, cfg_m;
   task automatic use_cfg(input int s);
      sel = s;
      if (s == 0) begin cfg_n = 2; cfg_s = 4; cfg_w = 14; cfg_m = 5;  end
      if (s == 1) begin cfg_n = 1; cfg_s = 1; cfg_w = 8;  cfg_m = 64; end
      if (s == 2) begin cfg_n = 2; cfg_s = 1; cfg_w = 14; cfg_m = 64; end
   endtask

   function automatic int sat(input int v, input int ww);
      int hi, lo;
      hi = (1 << (ww - 1)) - 1;
      lo = -(1 << (ww - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   int m_w [2];
   int m_b, m_ep, m_conv, m_y, m_cyc, m_rds;

   task automatic model(input int a);
      int upd, y, yh;
      m_w[0] = 0; m_w[1] = 0;
      m_b = 0; m_ep = 0; m_y = 0; m_cyc = 1; m_rds = 0;
      do begin
         upd = 0;
         for (int s = 0; s < cfg_s; s++) begin
            y = m_b;
            for (int i = 0; i < cfg_n; i++) y += m_w[i] * mx[s][i];
            m_y = y;
            m_rds++;
            yh = (y >= 0) ? 1 : -1;
            if (yh != mt[s]) begin
               upd = 1;
               m_b = sat(m_b + a * mt[s], cfg_w);
               for (int i = 0; i < cfg_n; i++)
                  m_w[i] = sat(m_w[i] + a * mt[s] * mx[s][i], cfg_w);
               m_cyc += 2 * cfg_n + 5;
            end else begin
               m_cyc += cfg_n + 4;
            end
         end
         m_ep++;
         m_cyc++;
      end while (upd != 0 && m_ep < cfg_m);
      m_conv = (upd == 0) ? 1 : 0;
   endtask

   int r_lat, r_rds, r_dones;

   task automatic run(input int a, input bit disturb);
      start = 1'b1;
      alpha = 4'(a);
      @(posedge clk); #1;
      start = 1'b0;
      r_lat = 1;
      r_rds = int'(rd_s);
      r_dones = int'(dn_s);
      while (!dn_s && r_lat < 4000) begin
         if (disturb) begin
            start = (r_lat >= 3 && r_lat < 20);
            alpha = start ? 4'($urandom_range(0, 15)) : 4'(a);
         end
         @(posedge clk); #1;
         r_lat++;
         r_rds += int'(rd_s);
         r_dones += int'(dn_s);
      end
      start = 1'b0;
      alpha = 4'(a);
      repeat (3) begin
         @(posedge clk); #1;
         r_dones += int'(dn_s);
         r_rds += int'(rd_s);
      end
   endtask

   task automatic cmp_run(input string p);
      chk({p, ".w0"}, w0_s, m_w[0]);
      if (cfg_n > 1) chk({p, ".w1"}, w1_s, m_w[1]);
      chk({p, ".bias"}, b_s, m_b);
      chk({p, ".y"}, y_s, m_y);
      chk({p, ".epoch"}, ep_s, m_ep);
      chk({p, ".conv"}, cv_s, m_conv);
      chk({p, ".cycles"}, r_lat, m_cyc);
      chk({p, ".reads"}, r_rds, m_rds);
      chk({p, ".dones"}, r_dones, 1);
      chk({p, ".ready"}, rdy_s, 1);
   endtask

   task automatic set_smp(input int s, input int x0, input int x1, input int t);
      mx[s][0] = x0; mx[s][1] = x1; mt[s] = t;
   endtask

   task automatic load_and();
      set_smp(0, 1, 1, 1);   set_smp(1, 1, -1, -1);
      set_smp(2, -1, 1, -1); set_smp(3, -1, -1, -1);
   endtask

   task automatic chk_reset(input string p);
      chk({p, ".ready"}, rdy_a, 1);
      chk({p, ".done"}, dn_a, 0);
      chk({p, ".rd"}, rd_a, 0);
      chk({p, ".addr"}, ad_a, 0);
      chk({p, ".epoch"}, ep_a, 0);
      chk({p, ".conv"}, cv_a, 0);
      chk({p, ".w"}, w_a, 0);
      chk({p, ".bias"}, b_a, 0);
      chk({p, ".y"}, y_a, 0);
   endtask

   initial begin
      int n, a;
      rst = 1'b1; start = 1'b0; alpha = '0;
      use_cfg(0);
      for (int s = 0; s < 4; s++) set_smp(s, 0, 0, 1);
      #2 rst = 1'b0;
      #1 chk_reset("rst0");
      #10 rst = 1'b1;
      @(posedge clk); #1;

      load_and();
      model(1);
      run(1, 1'b0);
      cmp_run("and");
      chk("and.w0k", w0_s, 1);
      chk("and.w1k", w1_s, 1);
      chk("and.biask", b_s, -1);
      chk("and.epochk", ep_s, 3);
      chk("and.convk", cv_s, 1);

      set_smp(0, 1, 1, -1);  set_smp(1, 1, -1, 1);
      set_smp(2, -1, 1, 1);  set_smp(3, -1, -1, -1);
      model(1);
      run(1, 1'b0);
      cmp_run("xor");
      chk("xor.epochk", ep_s, 5);
      chk("xor.convk", cv_s, 0);

      model(0);
      run(0, 1'b0);
      cmp_run("alpha0");
      chk("alpha0.w0k", w0_s, 0);
      chk("alpha0.epochk", ep_s, 5);

      use_cfg(1);
      set_smp(0, 63, 0, -1);
      model(15);
      run(15, 1'b0);
      cmp_run("sat");
      chk("sat.w0k", w0_s, -128);
      chk("sat.biask", b_s, -15);
      chk("sat.epochk", ep_s, 2);
      chk("sat.convk", cv_s, 1);

      use_cfg(2);
      set_smp(0, 1, 1, 1);
      model(1);
      run(1, 1'b0);
      cmp_run("cyc");
      chk("cyc.latk", r_lat, 8);
      chk("cyc.rdk", r_rds, 1);

      use_cfg(0);
      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < 4; s++) begin
            mx[s][0] = int'($urandom_range(0, 127)) - 64;
            mx[s][1] = int'($urandom_range(0, 127)) - 64;
            mt[s] = ($urandom_range(0, 1) == 1) ? 1 : -1;
         end
         a = int'($urandom_range(0, 15));
         model(a);
         run(a, 1'b0);
         cmp_run("rnd");
      end

      load_and();
      start = 1'b1; alpha = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(ep_a == 8'd1 && rd_a) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrst.reach", longint'(n < 500), 1);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_reset("midrst");
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      model(1);
      run(1, 1'b0);
      cmp_run("rerun");

      model(1);
      run(1, 1'b1);
      cmp_run("busy");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/perceptron_trainer_n.md
Name: perceptron_trainer_n

Overview:
Parametrised N-input perceptron trainer with control and datapath in one block. It streams labelled bipolar samples from an external sample memory and computes y = b + sum(w_i*x_i) with a serial MAC. Weights and bias are updated with the perceptron rule. Training stops when a full epoch completes with no update, or when the epoch limit is reached. It succeeds the fixed 2-input neuron by generalising input count, widths, sample count and epoch limit, and by adding a run-time learning rate, saturation and convergence status.

Parameters:
N_IN, 2, number of inputs (1..16)
XW, 7, signed sample input width
WW, 14, signed weight/bias width
N_SMP, 4, samples per epoch (1..256)
MAX_EP, 64, epoch limit (1..255)
ALW, 4, unsigned learning-rate width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  start training; sampled only in IDLE/DONE
alpha  in  ALW  learning rate, unsigned; latched on accepted start
smp_rd  out  1  sample read strobe
smp_addr  out  clog2(N_SMP) (min 1)  sample index
smp_data  in  N_IN*XW+2  {t[1:0], x[N_IN-1]..x[0]}; valid 1 cycle after smp_rd; t = +1 or -1
ready  out  1  high in IDLE and DONE
done  out  1  1-cycle pulse on entry to DONE
converged  out  1  last run ended on an update-free epoch
epoch_cnt  out  8  epochs completed
w_flat  out  N_IN*WW  weights, w_i at [i*WW +: WW]
bias  out  WW  bias
y_out  out  WW+XW+clog2(N_IN+1)  last accumulated net input

Behaviour:
- Reset (rst=0, immediate, any state): FSM goes to IDLE. All outputs and registers are 0, except ready=1.
- States: IDLE, FETCH, LATCH, ACC, DECIDE, UPDATE, EPEND, DONE.
- IDLE/DONE with start=1:
  - latch alpha; clear weights, bias, epoch_cnt, converged, update flag and sample index;
  - go to FETCH.
- start in any other state is ignored.
- FETCH: smp_rd=1 and smp_addr=index for 1 cycle. Next state LATCH.
- LATCH: capture smp_data into x/t registers. Clear the accumulator. Next state ACC.
- ACC: N_IN+1 cycles. Cycle 0 adds bias; cycle k adds w_(k-1)*x_(k-1). Accumulator width is full, so there is no overflow.
- DECIDE:
  - y_out <= acc;
  - yhat = +1 if acc >= 0, else -1;
  - if yhat != t: set update flag, go to UPDATE;
  - otherwise advance.
- UPDATE: N_IN+1 cycles.
  - Cycle 0: bias += alpha*t.
  - Cycle k: w_(k-1) += alpha*t*x_(k-1).
  - Each result saturates to [-2^(WW-1), 2^(WW-1)-1].
- Advance:
  - if index < N_SMP-1: index+1, go to FETCH;
  - else: index wraps to 0, go to EPEND.
- Sample timing: N_IN+4 cycles with no update, 2N_IN+5 cycles with an update. EPEND adds 1 cycle per epoch.
- EPEND: epoch_cnt+1.
  - Update flag clear: converged=1, go to DONE.
  - Else if epoch_cnt+1 == MAX_EP: converged=0, go to DONE.
  - Else: clear the flag, go to FETCH.
- DONE: done=1 for one cycle. Weights, bias, y_out, epoch_cnt and converged hold until the next accepted start.
- alpha=0: no weight change ever occurs, so a misclassifying set runs to MAX_EP.
- smp_rd is never asserted outside FETCH.

Optional Feature:
Macro PERCEPTRON_THETA_EN.
- Defined:
  - extra port theta, input, WW, unsigned dead-zone threshold;
  - yhat = +1 if acc > theta, -1 if acc < -theta, else 0;
  - yhat = 0 always counts as misclassified and triggers UPDATE.
- Undefined: no theta port; sign rule as above (acc >= 0 gives +1).

Test Plan:
- Bipolar AND, N_IN=2, alpha=1, samples (1,1,+1), (1,-1,-1), (-1,1,-1), (-1,-1,-1) -> done with converged=1, epoch_cnt=3, w=(1,1), bias=-1.
- Bipolar XOR, MAX_EP=5, alpha=1 -> done after epoch 5, converged=0, epoch_cnt=5; one done pulse; ready=1.
- N_IN=1, WW=8, XW=7, alpha=15, single sample x=63, t=-1 -> epoch 1 update gives w=-128 (saturated from -945), bias=-15; epoch 2 update-free; converged=1, epoch_cnt=2.
- Cycle count, N_IN=2, N_SMP=1, AND sample (1,1,+1) with zero weights -> smp_rd pulses 1 cycle; done pulses exactly 8 cycles after start accepted (6 sample + EPEND + DONE entry).
- rst driven low during ACC of epoch 2 -> outputs 0 and ready=1 immediately, without waiting for a clock edge; a subsequent start retrains from zero weights with identical results to a clean run.
- start pulsed while busy in UPDATE, and alpha changed mid-run -> both have no effect; the result matches the undisturbed run.
